pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, control redirects from Execute, and multi-cycle data-memory accesses through a request/acknowledge handshake.
- Keeps 16-bit saturating counters of stall and flush cycles for performance visibility.

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, Execute redirects and
// multi-cycle data-memory waits, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] D_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] D_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] E_rd,
    input  logic                      E_RegWrite,
    input  logic [1:0]                E_result_src,
    input  logic                      E_pc_src,
    input  logic                      M_mem_req,
    input  logic                      dmem_ack,
    output logic                      dmem_req,
    output logic                      F_stall,
    output logic                      D_stall,
    output logic                      D_flush,
    output logic                      E_flush,
    output logic                      M_stall,
    output logic                      W_flush,
    output logic                      mem_busy,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_mem_hold;
    logic                 w_load_use;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    assign w_load_use = (E_result_src == 2'b01) && E_RegWrite &&
                        (E_rd != {REG_ADDR_WIDTH{1'b0}}) &&
                        ((E_rd == D_rs1) || (E_rd == D_rs2));

    // Next-state and control decode; everything is forced low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_hold  = 1'b0;
        dmem_req    = 1'b0;
        F_stall     = 1'b0;
        D_stall     = 1'b0;
        D_flush     = 1'b0;
        E_flush     = 1'b0;
        M_stall     = 1'b0;
        W_flush     = 1'b0;
        mem_busy    = 1'b0;
        if (rst) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    dmem_req   = M_mem_req;
                    w_mem_hold = M_mem_req && !dmem_ack;
                    if (w_mem_hold) begin
                        w_state_nxt = MEM_WAIT;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                MEM_WAIT: begin
                    dmem_req   = 1'b1;
                    mem_busy   = 1'b1;
                    w_mem_hold = !dmem_ack;
                    if (dmem_ack) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = MEM_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase

            // Memory hold freezes E, so redirect/load-use inputs wait unchanged.
            if (w_mem_hold) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                M_stall = 1'b1;
                W_flush = 1'b1;
            end else if (E_pc_src) begin
                D_flush = 1'b1;
                E_flush = 1'b1;
            end else if (w_load_use) begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_flush = 1'b1;
            end else begin
                F_stall = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
            r_flush_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (F_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if ((D_flush || E_flush) && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a random
// run against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  D_rs1, D_rs2, E_rd;
    logic        E_RegWrite;
    logic [1:0]  E_result_src;
    logic        E_pc_src, M_mem_req, dmem_ack;
    logic        dmem_req, F_stall, D_stall, D_flush, E_flush, M_stall, W_flush, mem_busy;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Packed view: {dmem_req,F_stall,D_stall,D_flush,E_flush,M_stall,W_flush,mem_busy}
    wire [7:0] ctl = {dmem_req, F_stall, D_stall, D_flush, E_flush, M_stall, W_flush, mem_busy};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .D_rs1(D_rs1), .D_rs2(D_rs2), .E_rd(E_rd),
        .E_RegWrite(E_RegWrite), .E_result_src(E_result_src), .E_pc_src(E_pc_src),
        .M_mem_req(M_mem_req), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .F_stall(F_stall), .D_stall(D_stall), .D_flush(D_flush), .E_flush(E_flush),
        .M_stall(M_stall), .W_flush(W_flush), .mem_busy(mem_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                         input logic pc, input logic req, input logic ack);
        @(negedge clk);
        rst = r; D_rs1 = rs1; D_rs2 = rs2; E_rd = rd; E_RegWrite = rw;
        E_result_src = rsrc; E_pc_src = pc; M_mem_req = req; dmem_ack = ack;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got=%b want=%b", ctl, 8'h00); end
        idle();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL reset_idle got=%b want=%b", ctl, 8'h00); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'b0110_1000) begin errors++; $display("FAIL load_use got=%b want=%b", ctl, 8'b0110_1000); end
        drive(1'b0, 5'd5, 5'd7, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL load_use_after got=%b want=%b", ctl, 8'h00); end
        checks++;
        if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_cnt got=%0d/%0d want=1/1", stall_cnt, flush_cnt);
        end
        // Load to x0 never creates a hazard.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL load_x0 got=%b want=%b", ctl, 8'h00); end
        // Matching register but not a load.
        drive(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL non_load got=%b want=%b", ctl, 8'h00); end
        // Hazard via rs2.
        drive(1'b0, 5'd1, 5'd12, 5'd12, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'b0110_1000) begin errors++; $display("FAIL load_use_rs2 got=%b want=%b", ctl, 8'b0110_1000); end
        idle();
        checks++;
        if (stall_cnt !== 16'd2) begin errors++; $display("FAIL load_use_rs2_cnt got=%0d want=2", stall_cnt); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctl !== 8'b0001_1000) begin errors++; $display("FAIL redirect_lu got=%b want=%b", ctl, 8'b0001_1000); end
        idle();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL redirect_cnt got=%0d/%0d want=0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== 8'b1110_0110) begin errors++; $display("FAIL mem_c1 got=%b want=%b", ctl, 8'b1110_0110); end
        for (int i = 2; i <= 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (ctl !== 8'b1110_0111) begin errors++; $display("FAIL mem_c%0d got=%b want=%b", i, ctl, 8'b1110_0111); end
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl !== 8'b1000_0001) begin errors++; $display("FAIL mem_ack got=%b want=%b", ctl, 8'b1000_0001); end
        idle();
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== 16'd3 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL mem_after got=%b/%0d/%0d want=00000000/3/0", ctl, stall_cnt, flush_cnt);
        end
        // Zero-wait access: no stall, no state change.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ctl !== 8'b1000_0000) begin errors++; $display("FAIL zero_wait got=%b want=%b", ctl, 8'b1000_0000); end
        // Stray ack without a request is ignored.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== 16'd3) begin
            errors++; $display("FAIL stray_ack got=%b/%0d want=00000000/3", ctl, stall_cnt);
        end
    endtask

    task automatic test_mem_redirect();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== 8'b1110_0110) begin errors++; $display("FAIL memrd_c1 got=%b want=%b", ctl, 8'b1110_0110); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctl !== 8'b1110_0111) begin errors++; $display("FAIL memrd_c2 got=%b want=%b", ctl, 8'b1110_0111); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (ctl !== 8'b1001_1001) begin errors++; $display("FAIL memrd_ack got=%b want=%b", ctl, 8'b1001_1001); end
        idle();
        checks++;
        if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
            errors++; $display("FAIL memrd_cnt got=%0d/%0d want=2/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL rst_wait_ctl got=%b want=%b", ctl, 8'h00); end
        idle();
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_wait_after got=%b/%0d want=00000000/0", ctl, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        repeat (65540) @(posedge clk);
        #2;
        checks++;
        if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL saturation got=%h/%h want=ffff/ffff", stall_cnt, flush_cnt);
        end
        idle();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturation_hold got=%h want=ffff", stall_cnt); end
    endtask

    task automatic test_random();
        bit waiting;
        int m_stall, m_flush;
        bit r, rw, pc, req, ack, hold, lu;
        logic [4:0] rs1, rs2, rd;
        logic [1:0] rsrc;
        logic [7:0] exp;
        do_reset();
        waiting = 1'b0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 2000; n++) begin
            r    = ($urandom_range(63) == 0);
            rs1  = 5'($urandom_range(3)); rs2 = 5'($urandom_range(3)); rd = 5'($urandom_range(3));
            rw   = 1'($urandom_range(1));
            rsrc = 2'($urandom_range(3));
            pc   = ($urandom_range(3) == 0);
            req  = waiting ? 1'b1 : ($urandom_range(2) == 0);
            ack  = ($urandom_range(2) == 0);
            drive(r, rs1, rs2, rd, rw, rsrc, pc, req, ack);
            exp = 8'h00;
            if (!r) begin
                hold = waiting ? !ack : (req && !ack);
                lu   = (rsrc == 2'b01) && rw && (rd != 5'd0) && (rd == rs1 || rd == rs2);
                exp[7] = waiting || req;
                exp[0] = waiting;
                if (hold)    exp[6:1] = 6'b110011;
                else if (pc) exp[6:1] = 6'b001100;
                else if (lu) exp[6:1] = 6'b110100;
            end
            checks++;
            if (ctl !== exp) begin errors++; $display("FAIL rand_ctl n=%0d got=%b want=%b", n, ctl, exp); end
            checks++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                errors++; $display("FAIL rand_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
            if (r) begin
                waiting = 1'b0; m_stall = 0; m_flush = 0;
            end else begin
                waiting = hold;
                if (exp[6] && m_stall < 65535) m_stall++;
                if ((exp[4] || exp[3]) && m_flush < 65535) m_flush++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; D_rs1 = 5'd0; D_rs2 = 5'd0; E_rd = 5'd0; E_RegWrite = 1'b0;
        E_result_src = 2'b00; E_pc_src = 1'b0; M_mem_req = 1'b0; dmem_ack = 1'b0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_mem_redirect();
        test_reset_in_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
